// File: rtl/out_block_tx.sv
// out_block_tx: fetches a block of 30-bit MIX words from memory, converts each
// 6-bit MIX character to ASCII and sends it as 8N1 UART frames. Every block
// ends with CR, LF. A start that arrives while a block is running is held and
// then run as soon as the LF stop bit has gone out.
module out_block_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int BLOCK_WORDS  = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] addressin,
  output logic        stop,
  output logic        request,
  output logic [11:0] addressout,
  input  logic        load,
  input  logic [29:0] in,
  output logic        busy,
  output logic        tx
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(BLOCK_WORDS + 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    SHIFT,
    SEND,
    CR,
    LF
  } state_t;

  state_t state_reg, state_next;

  // Block sequencing registers
  logic [11:0]   pointer_reg;
  logic [CW-1:0] counter_reg;
  logic [29:0]   shift_reg;
  logic [2:0]    char_idx_reg;
  logic [7:0]    char_reg;
  logic          lf_loaded_reg;
  logic          pending_reg;
  logic [11:0]   pend_addr_reg;
  logic          request_reg;
  logic          stop_reg;
  logic          busy_reg;

  // UART transmitter registers
  logic          uart_active_reg;
  logic [8:0]    uart_shift_reg;
  logic [3:0]    bit_idx_reg;
  logic [TW-1:0] timer_reg;
  logic          tx_reg;

  // Control strobes decoded from the FSM
  logic        accept;
  logic        capture;
  logic        pick;
  logic        char_step;
  logic        word_done;
  logic        lf_issue;
  logic        block_end;
  logic        uart_load;
  logic [7:0]  uart_byte;
  logic [11:0] accept_addr;
  logic        last_word;
  logic        uart_done;
  logic        uart_ready;

  // MIX character code to ASCII; codes without a printable mapping become '#'
  // (10, 20, 21) or '?' (56-63).
  function automatic logic [7:0] mix_to_ascii(input logic [5:0] code);
    logic [7:0] c;
    logic [7:0] a;
    c = {2'b00, code};
    if (code == 6'd0)       a = 8'h20;
    else if (code <= 6'd9)  a = 8'h40 + c;
    else if (code == 6'd10) a = 8'h23;
    else if (code <= 6'd19) a = 8'h3F + c;
    else if (code <= 6'd21) a = 8'h23;
    else if (code <= 6'd29) a = 8'h3D + c;
    else if (code <= 6'd39) a = 8'h12 + c;
    else begin
      case (code)
        6'd40:   a = 8'h2E;
        6'd41:   a = 8'h2C;
        6'd42:   a = 8'h28;
        6'd43:   a = 8'h29;
        6'd44:   a = 8'h2B;
        6'd45:   a = 8'h2D;
        6'd46:   a = 8'h2A;
        6'd47:   a = 8'h2F;
        6'd48:   a = 8'h3D;
        6'd49:   a = 8'h24;
        6'd50:   a = 8'h3C;
        6'd51:   a = 8'h3E;
        6'd52:   a = 8'h40;
        6'd53:   a = 8'h3B;
        6'd54:   a = 8'h3A;
        6'd55:   a = 8'h27;
        default: a = 8'h3F;
      endcase
    end
    return a;
  endfunction

  // The UART can take a new byte when idle, or in the very last cycle of a
  // stop bit so consecutive frames follow with no idle gap.
  assign uart_done   = uart_active_reg && (timer_reg == TW'(CLKS_PER_BIT - 1)) &&
                       (bit_idx_reg == 4'd9);
  assign uart_ready  = !uart_active_reg || uart_done;
  assign last_word   = (counter_reg == CW'(BLOCK_WORDS - 1));
  assign accept_addr = pending_reg ? pend_addr_reg : addressin;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state and control strobe decode
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    capture    = 1'b0;
    pick       = 1'b0;
    char_step  = 1'b0;
    word_done  = 1'b0;
    lf_issue   = 1'b0;
    block_end  = 1'b0;
    uart_load  = 1'b0;
    uart_byte  = 8'h00;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        // load only counts while our request is actually out
        if (request_reg && load) begin
          capture    = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        pick       = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        if (uart_ready) begin
          uart_load = 1'b1;
          uart_byte = char_reg;
          if (char_idx_reg == 3'd4) begin
            // next word is requested only once its predecessor's last char is in the UART
            word_done  = 1'b1;
            state_next = last_word ? CR : REQ;
          end else begin
            char_step  = 1'b1;
            state_next = SHIFT;
          end
        end
      end
      CR: begin
        if (uart_ready) begin
          uart_load  = 1'b1;
          uart_byte  = 8'h0D;
          state_next = LF;
        end
      end
      LF: begin
        if (!lf_loaded_reg) begin
          if (uart_ready) begin
            uart_load = 1'b1;
            uart_byte = 8'h0A;
            lf_issue  = 1'b1;
          end
        end else if (uart_done) begin
          // block is over only when the LF stop bit has fully gone out
          block_end = 1'b1;
          if (pending_reg || start) begin
            accept     = 1'b1;
            state_next = REQ;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Block datapath: pointer, word counter, char shifter, handshakes, pending start
  always_ff @(posedge clk) begin
    if (reset) begin
      pointer_reg   <= 12'd0;
      counter_reg   <= '0;
      shift_reg     <= 30'd0;
      char_idx_reg  <= 3'd0;
      char_reg      <= 8'h00;
      lf_loaded_reg <= 1'b0;
      pending_reg   <= 1'b0;
      pend_addr_reg <= 12'd0;
      request_reg   <= 1'b0;
      stop_reg      <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      stop_reg <= accept;
      if (accept) begin
        pointer_reg <= accept_addr;
        counter_reg <= '0;
        request_reg <= 1'b1;
        busy_reg    <= 1'b1;
        pending_reg <= 1'b0;
      end else if (start && (state_reg != IDLE) && !pending_reg) begin
        // only the first start during a block is remembered
        pending_reg   <= 1'b1;
        pend_addr_reg <= addressin;
      end
      if (capture) begin
        shift_reg    <= in;
        request_reg  <= 1'b0;
        char_idx_reg <= 3'd0;
      end
      if (pick) begin
        char_reg  <= mix_to_ascii(shift_reg[29:24]);
        shift_reg <= {shift_reg[23:0], 6'd0};
      end
      if (char_step) char_idx_reg <= char_idx_reg + 3'd1;
      if (word_done) begin
        pointer_reg <= pointer_reg + 12'd1;
        counter_reg <= counter_reg + CW'(1);
        if (!last_word) request_reg <= 1'b1;
      end
      if (lf_issue) lf_loaded_reg <= 1'b1;
      if (block_end) begin
        lf_loaded_reg <= 1'b0;
        if (!accept) busy_reg <= 1'b0;
      end
    end
  end

  // UART 8N1 transmitter: start bit, 8 data bits LSB first, stop bit
  always_ff @(posedge clk) begin
    if (reset) begin
      uart_active_reg <= 1'b0;
      uart_shift_reg  <= 9'h1FF;
      bit_idx_reg     <= 4'd0;
      timer_reg       <= '0;
      tx_reg          <= 1'b1;
    end else if (uart_load) begin
      uart_active_reg <= 1'b1;
      uart_shift_reg  <= {1'b1, uart_byte};
      bit_idx_reg     <= 4'd0;
      timer_reg       <= '0;
      tx_reg          <= 1'b0;
    end else if (uart_active_reg) begin
      if (timer_reg == TW'(CLKS_PER_BIT - 1)) begin
        timer_reg <= '0;
        if (bit_idx_reg == 4'd9) begin
          uart_active_reg <= 1'b0;
          tx_reg          <= 1'b1;
        end else begin
          bit_idx_reg    <= bit_idx_reg + 4'd1;
          tx_reg         <= uart_shift_reg[0];
          uart_shift_reg <= {1'b1, uart_shift_reg[8:1]};
        end
      end else begin
        timer_reg <= timer_reg + TW'(1);
      end
    end
  end

  assign stop       = stop_reg;
  assign request    = request_reg;
  assign addressout = pointer_reg;
  assign busy       = busy_reg;
  assign tx         = tx_reg;

endmodule

// File: tb/tb_out_block_tx.sv
// Bench for out_block_tx: table of hand-decoded words, random blocks checked
// against a lookup-string model, plus pending-start and mid-frame reset cases.
module tb_out_block_tx;

  localparam int CPB   = 4;
  localparam int BW    = 2;
  localparam int FRAME = 10 * CPB;
  localparam int FPB   = 5 * BW + 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] addressin;
  logic        stop;
  logic        request;
  logic [11:0] addressout;
  logic        load;
  logic [29:0] in;
  logic        busy;
  logic        tx;

  out_block_tx #(.CLKS_PER_BIT(CPB), .BLOCK_WORDS(BW)) u_dut (
    .clk(clk), .reset(reset), .start(start), .addressin(addressin),
    .stop(stop), .request(request), .addressout(addressout),
    .load(load), .in(in), .busy(busy), .tx(tx)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference MIX decoding: one printable char per code, indexed directly.
  function automatic logic [7:0] ref_char(input logic [5:0] code);
    string lut;
    lut = " ABCDEFGHI#JKLMNOPQR##STUVWXYZ0123456789.,()+-*/=$<>@;:'????????";
    return 8'(lut.getc(int'(code)));
  endfunction

  logic [29:0] mem [0:4095];
  logic [7:0]  exp_b[$];
  logic [11:0] exp_r[$];
  logic [7:0]  rx_q[$];
  longint      rx_t[$];
  logic [11:0] req_q[$];
  longint      stop_q[$];
  longint      busy_fall_q[$];

  // UART receiver: samples mid-bit on falling edges
  bit         rx_active = 0;
  int         rx_cnt;
  logic [7:0] rx_byte;
  longint     rx_start;
  initial forever begin
    @(negedge clk);
    if (reset === 1'b1) rx_active = 0;
    else if (!rx_active) begin
      if (tx === 1'b0) begin
        rx_active = 1; rx_cnt = 0; rx_start = cyc;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == CPB / 2) check("rx_start_bit", tx, 0);
      else if (rx_cnt == 9 * CPB + CPB / 2) begin
        check("rx_stop_bit", tx, 1);
        rx_q.push_back(rx_byte);
        rx_t.push_back(rx_start);
        rx_active = 0;
      end else if (rx_cnt % CPB == CPB / 2) rx_byte[rx_cnt / CPB - 1] = tx;
    end
  end

  // Memory responder with configurable latency and optional stray loads
  int fixed_delay = -1;
  bit stray_en = 0;
  bit req_seen = 0;
  bit stray = 0;
  int wait_cnt, cur_delay;
  initial begin
    load = 1'b0; in = 30'd0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        load = 1'b0; req_seen = 0; stray = 0;
      end else if (load) begin
        load = 1'b0;
        if (!stray) check("request_drops_on_load", request, 0);
        stray = 0;
      end else begin
        if (req_seen) check("request_held", request, 1);
        else if (request === 1'b1) begin
          req_seen = 1; req_q.push_back(addressout); wait_cnt = 0;
          cur_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
        end
        if (req_seen) begin
          if (wait_cnt >= cur_delay) begin
            load = 1'b1; stray = 0; in = mem[addressout]; req_seen = 0;
          end else wait_cnt++;
        end else if (stray_en && $urandom_range(0, 15) == 0) begin
          load = 1'b1; stray = 1; in = 30'($urandom);
        end
      end
    end
  end

  // stop / busy / request-width monitors
  logic stop_prev = 1'b0;
  logic busy_prev = 1'b0;
  int   req_hold = 0;
  int   last_req_hold = 0;
  initial forever begin
    @(negedge clk);
    if (stop === 1'b1) begin
      check("stop_one_cycle", stop_prev, 0);
      stop_q.push_back(cyc);
    end
    stop_prev = (stop === 1'b1);
    if (busy_prev && busy === 1'b0 && reset !== 1'b1) busy_fall_q.push_back(cyc);
    busy_prev = (busy === 1'b1);
    if (request === 1'b1) req_hold++;
    else if (req_hold > 0) begin last_req_hold = req_hold; req_hold = 0; end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic expect_block(input logic [11:0] a);
    logic [11:0] wa;
    logic [29:0] word;
    for (int w = 0; w < BW; w++) begin
      wa = a + 12'(w);
      exp_r.push_back(wa);
      word = mem[wa];
      for (int c = 0; c < 5; c++) exp_b.push_back(ref_char(word[29 - 6 * c -: 6]));
    end
    exp_b.push_back(8'h0D);
    exp_b.push_back(8'h0A);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin @(negedge clk); n++; end
    check("idle_within_budget", busy, 0);
  endtask

  task automatic clear_all();
    rx_q.delete(); rx_t.delete(); req_q.delete(); stop_q.delete();
    busy_fall_q.delete(); exp_b.delete(); exp_r.delete();
  endtask

  task automatic verify(input logic [11:0] a);
    int nb, nr;
    @(negedge clk);
    $display("block @0x%03h: %0d frames, %0d requests", a, rx_q.size(), req_q.size());
    check("frame_count", rx_q.size(), exp_b.size());
    nb = (rx_q.size() < exp_b.size()) ? rx_q.size() : exp_b.size();
    for (int i = 0; i < nb; i++) begin
      check($sformatf("byte%0d", i), rx_q[i], exp_b[i]);
      if (i % FPB != 0) check($sformatf("gap%0d", i), rx_t[i] - rx_t[i - 1], FRAME);
    end
    check("busy_fall_count", busy_fall_q.size(), 1);
    if (busy_fall_q.size() > 0 && rx_t.size() > 0)
      check("busy_fall_after_lf", busy_fall_q[0], rx_t[rx_t.size() - 1] + FRAME);
    check("request_count", req_q.size(), exp_r.size());
    nr = (req_q.size() < exp_r.size()) ? req_q.size() : exp_r.size();
    for (int i = 0; i < nr; i++) check($sformatf("req_addr%0d", i), req_q[i], exp_r[i]);
    clear_all();
  endtask

  task automatic run_block(input logic [11:0] a);
    longint t0;
    @(negedge clk);
    start = 1'b1; addressin = a; t0 = cyc;
    @(negedge clk);
    start = 1'b0; addressin = 12'($urandom);
    check("stop_next_cycle", stop, 1);
    check("busy_next_cycle", busy, 1);
    wait_idle(2000);
    @(negedge clk);
    check("stop_count", stop_q.size(), 1);
    if (stop_q.size() > 0) check("stop_time", stop_q[0], t0 + 1);
    verify(a);
  endtask

  typedef struct {
    logic [29:0] word;
    logic [39:0] exp;
  } vec_t;

  vec_t        tbl [8];
  logic [11:0] blk_addr [4];
  int          blk_delay [4];

  initial begin
    logic [11:0] a, b, c, a1;
    longint t0, s;
    int viol, n;

    tbl[0] = '{30'o0102030405, 40'h4142434445};
    tbl[1] = '{{6'd30, 6'd0, 6'd10, 6'd56, 6'd55}, 40'h3020233F27};
    tbl[2] = '{{6'd9, 6'd11, 6'd19, 6'd20, 6'd21}, 40'h494A522323};
    tbl[3] = '{{6'd22, 6'd29, 6'd39, 6'd40, 6'd41}, 40'h535A392E2C};
    tbl[4] = '{{6'd42, 6'd43, 6'd44, 6'd45, 6'd46}, 40'h28292B2D2A};
    tbl[5] = '{{6'd47, 6'd48, 6'd49, 6'd50, 6'd51}, 40'h2F3D243C3E};
    tbl[6] = '{{6'd52, 6'd53, 6'd54, 6'd63, 6'd31}, 40'h403B3A3F31};
    tbl[7] = '{{6'd1, 6'd35, 6'd0, 6'd26, 6'd12}, 40'h413520574B};
    blk_addr[0] = 12'h010; blk_delay[0] = 0;
    blk_addr[1] = 12'hFFF; blk_delay[1] = 2;
    blk_addr[2] = 12'h5A3; blk_delay[2] = 1;
    blk_addr[3] = 12'h7FE; blk_delay[3] = 5;

    for (int i = 0; i < 4096; i++) mem[i] = 30'($urandom);

    reset = 1'b1; start = 1'b0; addressin = 12'd0;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_request", request, 0);
    check("reset_stop", stop, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    clear_all();

    // table-driven blocks: hand-decoded words
    for (int bi = 0; bi < 4; bi++) begin
      a  = blk_addr[bi];
      a1 = a + 12'd1;
      mem[a]  = tbl[2 * bi].word;
      mem[a1] = tbl[2 * bi + 1].word;
      exp_r.push_back(a);
      exp_r.push_back(a1);
      for (int w = 0; w < 2; w++)
        for (int ch = 0; ch < 5; ch++) exp_b.push_back(tbl[2 * bi + w].exp[39 - 8 * ch -: 8]);
      exp_b.push_back(8'h0D);
      exp_b.push_back(8'h0A);
      fixed_delay = blk_delay[bi];
      run_block(a);
      if (bi == 3) check("request_hold_with_5_cycle_delay", last_req_hold, 6);
    end

    // random blocks with random latency and stray loads
    fixed_delay = -1;
    stray_en = 1;
    for (int r = 0; r < 5; r++) begin
      a = 12'($urandom);
      expect_block(a);
      run_block(a);
    end
    stray_en = 0;

    // start during a block: held until LF done, third start ignored
    a = 12'($urandom); b = 12'($urandom); c = 12'($urandom);
    expect_block(a);
    expect_block(b);
    @(negedge clk);
    start = 1'b1; addressin = a; t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    check("pend_first_stop", stop, 1);
    repeat (100) @(negedge clk);
    start = 1'b1; addressin = b;
    @(negedge clk);
    start = 1'b0;
    check("stop_withheld", stop, 0);
    check("busy_while_pending", busy, 1);
    repeat (100) @(negedge clk);
    start = 1'b1; addressin = c;
    @(negedge clk);
    start = 1'b0;
    check("third_start_no_stop", stop, 0);
    wait_idle(3000);
    @(negedge clk);
    check("pend_stop_count", stop_q.size(), 2);
    if (stop_q.size() == 2 && rx_t.size() >= FPB) begin
      check("pend_stop0_time", stop_q[0], t0 + 1);
      check("pend_stop1_after_lf", stop_q[1], rx_t[FPB - 1] + FRAME);
    end
    verify(a);

    // reset during the third data bit of the first frame
    a = 12'($urandom);
    @(negedge clk);
    start = 1'b1; addressin = a;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!rx_active && n < 300) begin @(negedge clk); n++; end
    check("frame_started", rx_active, 1);
    s = rx_start;
    while (cyc < s + 13) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_request", request, 0);
    check("rst_stop", stop, 0);
    reset = 1'b0;
    viol = 0;
    repeat (150) begin
      @(negedge clk);
      if (tx !== 1'b1 || request !== 1'b0 || stop !== 1'b0 || busy !== 1'b0) viol++;
    end
    check("quiet_after_reset", viol, 0);
    clear_all();

    // recovery block after reset
    a = 12'($urandom);
    expect_block(a);
    run_block(a);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
